piano_note_player: RTL and testbench
====================================

PIANO_NOTE_PLAYER -- requirements
Module: piano_note_player

Interface
REQ-001 SHALL have parameter DUR_W, default 6: width of the note duration in beats.
REQ-002 SHALL have parameter RELEASE_BEATS, default 2: number of beats voice_done is held before note_done.
REQ-003 SHALL have port clk, input, 1: single clock for all state.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port play_enable, input, 1: high = playing; low = pause.
REQ-006 SHALL have port load_new_note, input, 1: one-cycle request from the song reader.
REQ-007 SHALL have port note_in, input, 6: note index; 0 = rest.
REQ-008 SHALL have port duration_in, input, DUR_W: length of the note in beats.
REQ-009 SHALL have port beat, input, 1: one-cycle tick, 48 per second.
REQ-010 SHALL have port generate_next, input, 1: sample request from the codec.
REQ-011 SHALL have port voice_freq, output, 20: step size for the voice.
REQ-012 SHALL have port voice_note, output, 6: latched note index for the voice.
REQ-013 SHALL have port voice_load, output, 1: one-cycle pulse telling the voice to start a new note.
REQ-014 SHALL have port voice_generate_next, output, 1: gated sample request to the voice.
REQ-015 SHALL have port voice_done, output, 1: release or decay phase is active.
REQ-016 SHALL have port note_done, output, 1: one-cycle pulse to the song reader when the note is finished.
REQ-017 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-018 SHALL implement the states IDLE, LOOKUP, START, PLAY and RELEASE.
REQ-019 IDLE: a load_new_note sampled high SHALL latch note_in and duration_in and move to LOOKUP.
REQ-020 load_new_note SHALL be ignored in every state other than IDLE.
REQ-021 LOOKUP SHALL last exactly one cycle, which covers the registered ROM read, then move to START.
REQ-022 START SHALL last one cycle.
REQ-023 In START, voice_load SHALL be 1 and voice_freq/voice_note SHALL already hold the new values.
REQ-024 START SHALL go to PLAY, or go directly to RELEASE if the latched duration is 0.
REQ-025 PLAY: each beat that arrives while play_enable=1 SHALL decrement the duration counter.
REQ-026 PLAY: the beat that makes the duration counter 0 SHALL move the state to RELEASE and load the release counter with RELEASE_BEATS.
REQ-027 RELEASE: voice_done SHALL be 1.
REQ-028 RELEASE: each beat that arrives while play_enable=1 SHALL decrement the release counter.
REQ-029 RELEASE: the beat that makes the release counter 0 SHALL assert note_done for 1 cycle in the same cycle as the transition to IDLE.
REQ-030 A beat that arrives while the state is IDLE, LOOKUP or START SHALL not change any counter.
REQ-031 voice_generate_next SHALL equal generate_next AND play_enable AND (state is PLAY or RELEASE), as a combinational output.
REQ-032 play_enable=0 SHALL freeze both counters and the state in PLAY and RELEASE.
REQ-033 LOOKUP and START SHALL always complete, whatever the value of play_enable.
REQ-034 Note 0 (rest) SHALL give voice_freq=0 and SHALL still follow the full timing of a played note.
REQ-035 voice_freq SHALL be loaded from the ROM only at the LOOKUP-to-START transition, and SHALL hold between notes.
REQ-036 voice_note SHALL be loaded only at the LOOKUP-to-START transition, and SHALL hold between notes.
REQ-037 ROM entry n (1..63) SHALL be round(f*2^20/48000), with f = 440*2^((n-49)/12) Hz; entry 0 SHALL be 0.
REQ-038 The ROM entry for note 49 SHALL be 9612.
REQ-039 All counters SHALL be unsigned and SHALL never wrap: a decrement happens only while the count is greater than 0.

Reset
REQ-040 reset=0 SHALL force the state to IDLE at once, with no clock, regardless of the current state.
REQ-041 reset=0 SHALL clear both counters, voice_freq, voice_note, voice_load, voice_done, note_done and busy to 0.
REQ-042 voice_generate_next SHALL be 0 while reset=0.
REQ-043 A reset during PLAY or RELEASE SHALL NOT produce a note_done pulse.

Structure
REQ-044 A shared package SHALL hold the state encoding, the ROM depth (64), the sample rate (48000) and the frequency width (20).
REQ-045 A single sub-module, piano_freq_rom, SHALL be used: a 64x20 ROM with a registered output and a 1-cycle read latency.
REQ-046 All other logic SHALL stay within piano_note_player.

Verification
REQ-047 Normal note: load note 49, duration 3, play_enable=1 -> voice_load 2 cycles after the load with voice_freq=9612; voice_done rises on the 3rd beat; note_done pulses once on the 5th beat.
REQ-048 Zero duration: load duration 0 -> START is followed directly by RELEASE; note_done pulses on the 2nd beat.
REQ-049 Pause: drop play_enable for 4 beats during PLAY -> the counter does not change and voice_generate_next=0; the total note length is still 3+2 effective beats.
REQ-050 Rest and ignored load: load note 0, duration 1 -> voice_freq=0 and note_done after 3 beats; a second load_new_note during PLAY is ignored.
REQ-051 Mid-note reset: assert reset during RELEASE -> all outputs are 0 immediately, no note_done, and the block accepts the next load normally.
REQ-052 Simultaneous events: beat and load_new_note in the same cycle in IDLE -> the load is accepted and the beat does not decrement the counter.

Source files
------------

// File: rtl/piano_note_player_pkg.sv
// Shared definitions for the note player: state encoding, ROM geometry, step-size formula.
// Latency: none (types, constants and an elaboration-time function only).
// Backpressure: not applicable.
package piano_note_player_pkg;

  localparam int ROM_DEPTH   = 64;
  localparam int SAMPLE_RATE = 48000;
  localparam int FREQ_W      = 20;
  localparam int NOTE_W      = $clog2(ROM_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_START   = 3'd2,
    ST_PLAY    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // Phase step for equal-tempered note n (A4 = note 49 = 440 Hz) as a
  // FREQ_W-bit fraction of one cycle per sample. Note 0 is a rest.
  // Only ever called with constant arguments, so it folds to a table.
  function automatic logic [FREQ_W-1:0] note_step(input int n);
    real f_hz;
    real step;
    if (n <= 0) return '0;
    f_hz = 440.0 * (2.0 ** (real'(n - 49) / 12.0));
    step = f_hz * (2.0 ** FREQ_W) / real'(SAMPLE_RATE);
    return FREQ_W'($rtoi(step + 0.5));
  endfunction

endpackage

// File: rtl/piano_freq_rom.sv
// Note-index to voice step-size table, 64 x 20, registered output.
// Latency: 1 cycle from an enabled read to dout.
// Backpressure: none; dout holds its last value while en is low.
module piano_freq_rom
  import piano_note_player_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [NOTE_W-1:0] addr,
  output logic [FREQ_W-1:0] dout
);

  logic [FREQ_W-1:0] rom_tbl [ROM_DEPTH];

  for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_tbl
    assign rom_tbl[g] = note_step(g);
  end

  // Registered read port; only advances when the player asks for a lookup.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout <= '0;
    end else if (en) begin
      dout <= rom_tbl[addr];
    end
  end

endmodule

// File: rtl/piano_note_player.sv
// Plays one note: looks up its step size, starts the voice, counts play then release beats.
// Latency: voice_load 2 cycles after an accepted load; note_done on the final release beat.
// Backpressure: load_new_note is only taken while idle; play_enable=0 freezes counting and sample requests.
module piano_note_player
  import piano_note_player_pkg::*;
#(
  parameter int DUR_W         = 6,
  parameter int RELEASE_BEATS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_enable,
  input  logic              load_new_note,
  input  logic [NOTE_W-1:0] note_in,
  input  logic [DUR_W-1:0]  duration_in,
  input  logic              beat,
  input  logic              generate_next,
  output logic [FREQ_W-1:0] voice_freq,
  output logic [NOTE_W-1:0] voice_note,
  output logic              voice_load,
  output logic              voice_generate_next,
  output logic              voice_done,
  output logic              note_done,
  output logic              busy
);

  localparam int               REL_W    = (RELEASE_BEATS < 2) ? 1 : $clog2(RELEASE_BEATS + 1);
  localparam logic [REL_W-1:0] REL_INIT = REL_W'(RELEASE_BEATS);

  state_t            state_q, state_nxt;
  logic [DUR_W-1:0]  dur_q, dur_nxt;
  logic [REL_W-1:0]  rel_q, rel_nxt;
  logic [NOTE_W-1:0] note_q, note_nxt;
  logic [FREQ_W-1:0] freq_nxt;
  logic [NOTE_W-1:0] vnote_nxt;
  logic [FREQ_W-1:0] rom_q;
  logic              rom_en;
  logic              beat_tick;

  // Only beats seen while playing count; a paused beat is simply lost.
  assign beat_tick = beat & play_enable;

  // The ROM is addressed straight from note_in on the accepting cycle, so its
  // registered output is ready during LOOKUP and can be captured into voice_freq
  // on the way into START.
  piano_freq_rom u_rom (
    .clk   (clk),
    .reset (reset),
    .en    (rom_en),
    .addr  (note_in),
    .dout  (rom_q)
  );

  // State, counters and the voice-facing note registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      dur_q      <= '0;
      rel_q      <= '0;
      note_q     <= '0;
      voice_freq <= '0;
      voice_note <= '0;
    end else begin
      state_q    <= state_nxt;
      dur_q      <= dur_nxt;
      rel_q      <= rel_nxt;
      note_q     <= note_nxt;
      voice_freq <= freq_nxt;
      voice_note <= vnote_nxt;
    end
  end

  // Next state, counter updates and the note_done pulse.
  always_comb begin
    state_nxt = state_q;
    dur_nxt   = dur_q;
    rel_nxt   = rel_q;
    note_nxt  = note_q;
    freq_nxt  = voice_freq;
    vnote_nxt = voice_note;
    rom_en    = 1'b0;
    note_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_new_note) begin
          note_nxt  = note_in;
          dur_nxt   = duration_in;
          rom_en    = 1'b1;
          state_nxt = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        freq_nxt  = rom_q;
        vnote_nxt = note_q;
        state_nxt = ST_START;
      end
      ST_START: begin
        if (dur_q == '0) begin
          rel_nxt   = REL_INIT;
          state_nxt = ST_RELEASE;
        end else begin
          state_nxt = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (beat_tick && (dur_q != '0)) begin
          dur_nxt = dur_q - DUR_W'(1);
          if (dur_q == DUR_W'(1)) begin
            rel_nxt   = REL_INIT;
            state_nxt = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        if (beat_tick && (rel_q != '0)) begin
          rel_nxt = rel_q - REL_W'(1);
          if (rel_q == REL_W'(1)) begin
            note_done = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy                = (state_q != ST_IDLE);
  assign voice_load          = (state_q == ST_START);
  assign voice_done          = (state_q == ST_RELEASE);
  assign voice_generate_next = generate_next & play_enable &
                               ((state_q == ST_PLAY) | (state_q == ST_RELEASE));

endmodule

// File: tb/tb_piano_note_player.sv
// Randomised and directed bench for piano_note_player against a beat-counting model.
// Latency: model tracks accept age and effective beats per note.
// Backpressure: exercised through play_enable pauses and ignored loads.
module tb_piano_note_player;

  localparam int DUR_W = 6;
  localparam int RB    = 2;

  logic        clk;
  logic        reset;
  logic        play_enable;
  logic        load_new_note;
  logic [5:0]  note_in;
  logic [DUR_W-1:0] duration_in;
  logic        beat;
  logic        generate_next;
  logic [19:0] voice_freq;
  logic [5:0]  voice_note;
  logic        voice_load;
  logic        voice_generate_next;
  logic        voice_done;
  logic        note_done;
  logic        busy;

  int n_vec;
  int n_err;

  // Reference table and per-note model state.
  int ref_rom [64];
  bit m_active;
  int m_age;
  int m_note;
  int m_dur;
  int m_eff;
  int m_freq;
  int m_vnote;

  piano_note_player #(.DUR_W(DUR_W), .RELEASE_BEATS(RB)) dut (
    .clk                 (clk),
    .reset               (reset),
    .play_enable         (play_enable),
    .load_new_note       (load_new_note),
    .note_in             (note_in),
    .duration_in         (duration_in),
    .beat                (beat),
    .generate_next       (generate_next),
    .voice_freq          (voice_freq),
    .voice_note          (voice_note),
    .voice_load          (voice_load),
    .voice_generate_next (voice_generate_next),
    .voice_done          (voice_done),
    .note_done           (note_done),
    .busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %0d, expected %0d at %0t", tag, name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_freq, input logic [31:0] e_note,
                         input logic [31:0] e_load, input logic [31:0] e_vgn,
                         input logic [31:0] e_done, input logic [31:0] e_nd,
                         input logic [31:0] e_busy);
    check(tag, "voice_freq", 32'(voice_freq), e_freq);
    check(tag, "voice_note", 32'(voice_note), e_note);
    check(tag, "voice_load", 32'(voice_load), e_load);
    check(tag, "voice_generate_next", 32'(voice_generate_next), e_vgn);
    check(tag, "voice_done", 32'(voice_done), e_done);
    check(tag, "note_done", 32'(note_done), e_nd);
    check(tag, "busy", 32'(busy), e_busy);
  endtask

  // Every cycle: compare DUT outputs to the model, then advance the model
  // by what the coming clock edge will see.
  always @(negedge clk) begin : cmp
    bit run;
    bit tick;
    bit fin;
    if (!reset) begin
      chk_all("in_reset", 0, 0, 0, 0, 0, 0, 0);
      m_active = 1'b0;
      m_age    = 0;
      m_eff    = 0;
      m_freq   = 0;
      m_vnote  = 0;
    end else begin
      run  = m_active && (m_age >= 3);
      tick = beat && play_enable;
      fin  = run && tick && (m_eff + 1 == m_dur + RB);
      chk_all("model", 32'(m_freq), 32'(m_vnote),
              32'(m_active && (m_age == 2)),
              32'(generate_next && play_enable && run),
              32'(run && (m_eff >= m_dur)),
              32'(fin), 32'(m_active));
      if (!m_active) begin
        if (load_new_note) begin
          m_active = 1'b1;
          m_age    = 1;
          m_note   = int'(note_in);
          m_dur    = int'(duration_in);
          m_eff    = 0;
        end
      end else begin
        if (m_age == 1) begin
          m_freq  = ref_rom[m_note];
          m_vnote = m_note;
        end
        if (run && tick) begin
          m_eff++;
          if (m_eff == m_dur + RB) m_active = 1'b0;
        end
        if (m_age < 3) m_age++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One beat pulse; note_done is sampled before the edge that takes the beat,
  // voice_done just after it. Followed by one quiet cycle.
  task automatic do_beat(output logic nd, output logic vd);
    beat = 1'b1;
    #2 nd = note_done;
    @(posedge clk);
    #1;
    beat = 1'b0;
    vd = voice_done;
    step(1);
  endtask

  task automatic beats_until_done(input int max_beats, output int vd_at, output int nd_at);
    logic nd;
    logic vd;
    vd_at = 0;
    nd_at = 0;
    for (int i = 1; i <= max_beats; i++) begin
      do_beat(nd, vd);
      if (vd && (vd_at == 0)) vd_at = i;
      if (nd) begin
        nd_at = i;
        break;
      end
    end
  endtask

  task automatic load_note(input int n, input int d);
    load_new_note = 1'b1;
    note_in       = 6'(n);
    duration_in   = DUR_W'(d);
    step(1);
    load_new_note = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2000000");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int vd_at;
    int nd_at;
    logic nd;
    logic vd;
    n_vec = 0;
    n_err = 0;
    for (int n = 0; n < 64; n++) begin
      if (n == 0) ref_rom[n] = 0;
      else ref_rom[n] = $rtoi(440.0 * (2.0 ** (real'(n - 49) / 12.0)) * 1048576.0 / 48000.0 + 0.5);
    end
    // Pin the model table to hand-computed values.
    check("table", "rom49", 32'(ref_rom[49]), 9612);
    check("table", "rom61", 32'(ref_rom[61]), 19224);
    check("table", "rom37", 32'(ref_rom[37]), 4806);
    check("table", "rom1", 32'(ref_rom[1]), 601);

    reset         = 1'b0;
    play_enable   = 1'b1;
    load_new_note = 1'b0;
    note_in       = '0;
    duration_in   = '0;
    beat          = 1'b0;
    generate_next = 1'b0;
    #1;
    chk_all("reset_state", 0, 0, 0, 0, 0, 0, 0);
    step(2);
    reset = 1'b1;
    step(1);

    // Normal note 49, duration 3.
    load_note(49, 3);
    check("normal", "lookup_load", 32'(voice_load), 0);
    step(1);
    check("normal", "start_load", 32'(voice_load), 1);
    check("normal", "start_freq", 32'(voice_freq), 9612);
    check("normal", "start_note", 32'(voice_note), 49);
    step(1);
    beats_until_done(20, vd_at, nd_at);
    check("normal", "voice_done_beat", 32'(vd_at), 3);
    check("normal", "note_done_beat", 32'(nd_at), 5);
    check("normal", "idle_busy", 32'(busy), 0);

    // Zero duration goes straight to release.
    load_note(10, 0);
    step(1);
    check("zero_dur", "start_load", 32'(voice_load), 1);
    step(1);
    check("zero_dur", "release_direct", 32'(voice_done), 1);
    beats_until_done(20, vd_at, nd_at);
    check("zero_dur", "note_done_beat", 32'(nd_at), 2);

    // Pause for four beats during play.
    load_note(49, 3);
    step(2);
    do_beat(nd, vd);
    play_enable   = 1'b0;
    generate_next = 1'b1;
    #1;
    check("pause", "vgn_paused", 32'(voice_generate_next), 0);
    repeat (4) do_beat(nd, vd);
    check("pause", "still_playing", 32'(voice_done), 0);
    check("pause", "busy", 32'(busy), 1);
    play_enable = 1'b1;
    #1;
    check("pause", "vgn_resumed", 32'(voice_generate_next), 1);
    generate_next = 1'b0;
    beats_until_done(20, vd_at, nd_at);
    check("pause", "remaining_beats", 32'(nd_at), 4);

    // Rest note with an ignored load during play.
    load_note(0, 1);
    step(1);
    check("rest", "start_freq", 32'(voice_freq), 0);
    step(1);
    load_note(5, 9);
    beats_until_done(20, vd_at, nd_at);
    check("rest", "note_done_beat", 32'(nd_at), 3);
    check("rest", "note_kept", 32'(voice_note), 0);
    check("rest", "idle_busy", 32'(busy), 0);

    // Reset on what would be the final release beat.
    load_note(49, 1);
    step(2);
    do_beat(nd, vd);
    do_beat(nd, vd);
    check("midreset", "in_release", 32'(voice_done), 1);
    generate_next = 1'b1;
    beat          = 1'b1;
    reset         = 1'b0;
    #1;
    chk_all("midreset", 0, 0, 0, 0, 0, 0, 0);
    step(2);
    beat          = 1'b0;
    generate_next = 1'b0;
    reset         = 1'b1;
    step(1);
    load_note(20, 0);
    step(1);
    check("midreset", "reload_load", 32'(voice_load), 1);
    check("midreset", "reload_note", 32'(voice_note), 20);
    step(1);
    beats_until_done(20, vd_at, nd_at);
    check("midreset", "reload_done_beat", 32'(nd_at), 2);

    // Beat coinciding with an accepted load is not counted.
    beat = 1'b1;
    load_note(49, 2);
    beat = 1'b0;
    step(2);
    beats_until_done(20, vd_at, nd_at);
    check("simul", "note_done_beat", 32'(nd_at), 4);

    // Random traffic, checked every cycle by the model.
    for (int c = 0; c < 5000; c++) begin
      reset         = ($urandom_range(0, 399) != 0);
      load_new_note = ($urandom_range(0, 11) == 0);
      note_in       = 6'($urandom_range(0, 63));
      duration_in   = DUR_W'($urandom_range(0, 6));
      beat          = ($urandom_range(0, 2) == 0);
      play_enable   = ($urandom_range(0, 7) != 0);
      generate_next = ($urandom_range(0, 1) == 1);
      step(1);
    end
    reset         = 1'b1;
    load_new_note = 1'b0;
    beat          = 1'b0;
    generate_next = 1'b0;
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
